// File: rtl/reset_sequencer.sv
// Ordered reset release for N_STAGES downstream domains sharing one clock.
// Stages leave reset one at a time, each gated on the previous stage's ready ack.
module reset_sequencer #(
  parameter int N_STAGES  = 4,
  parameter int HOLD_CYC  = 8,
  parameter int STAGE_DLY = 4,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 8
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                sw_rst_req_i,
  input  logic [N_STAGES-1:0] stage_done_i,
  output logic [N_STAGES-1:0] rstn_stage_o,
  output logic                seq_busy_o,
  output logic                seq_done_o,
  output logic [N_STAGES-1:0] timeout_o
);

  typedef enum logic [1:0] {
    ST_HOLD     = 2'd0,
    ST_GAP      = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_DONE     = 2'd3
  } state_t;

  localparam int K_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]    DLY_LAST  = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0]    TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [K_W-1:0]      K_LAST    = K_W'(N_STAGES - 1);
  localparam logic [N_STAGES-1:0] STAGE_ONE = N_STAGES'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [K_W-1:0]      r_k;
  logic [K_W-1:0]      w_k_nxt;
  logic [N_STAGES-1:0] r_rstn_stage;
  logic [N_STAGES-1:0] w_rstn_stage_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic [N_STAGES-1:0] r_timeout;
  logic [N_STAGES-1:0] w_timeout_nxt;

  logic [N_STAGES-1:0] w_k_mask;
  logic                w_ack;
  logic                w_advance;

  // Only the ack of the stage currently being waited on matters.
  assign w_k_mask = STAGE_ONE << r_k;
  assign w_ack    = |(stage_done_i & w_k_mask);

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_k_nxt          = r_k;
    w_rstn_stage_nxt = r_rstn_stage;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_timeout_nxt    = r_timeout;
    w_advance        = 1'b0;

    if (sw_rst_req_i) begin
      w_state_nxt      = ST_HOLD;
      w_cnt_nxt        = {CNT_W{1'b0}};
      w_k_nxt          = {K_W{1'b0}};
      w_rstn_stage_nxt = {N_STAGES{1'b0}};
      w_busy_nxt       = 1'b1;
      w_done_nxt       = 1'b0;
      w_timeout_nxt    = {N_STAGES{1'b0}};
    end else begin
      case (r_state)
        ST_HOLD: begin
          w_rstn_stage_nxt = {N_STAGES{1'b0}};
          if (r_cnt == HOLD_LAST) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = {CNT_W{1'b0}};
            w_k_nxt     = {K_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (r_cnt == DLY_LAST) begin
            w_rstn_stage_nxt = r_rstn_stage | w_k_mask;
            w_state_nxt      = ST_WAIT_ACK;
            w_cnt_nxt        = {CNT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          // A timed-out stage keeps its release; only the flag records it.
          if (w_ack) begin
            w_advance = 1'b1;
          end else if (r_cnt == TO_LAST) begin
            w_timeout_nxt = r_timeout | w_k_mask;
            w_advance     = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          w_rstn_stage_nxt = {N_STAGES{1'b1}};
          w_busy_nxt       = 1'b0;
          w_done_nxt       = 1'b1;
        end
        default: begin
          w_state_nxt      = ST_HOLD;
          w_cnt_nxt        = {CNT_W{1'b0}};
          w_k_nxt          = {K_W{1'b0}};
          w_rstn_stage_nxt = {N_STAGES{1'b0}};
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
          w_timeout_nxt    = {N_STAGES{1'b0}};
        end
      endcase
    end

    if (w_advance) begin
      w_cnt_nxt = {CNT_W{1'b0}};
      if (r_k == K_LAST) begin
        w_state_nxt      = ST_DONE;
        w_rstn_stage_nxt = {N_STAGES{1'b1}};
        w_busy_nxt       = 1'b0;
        w_done_nxt       = 1'b1;
      end else begin
        w_state_nxt = ST_GAP;
        w_k_nxt     = r_k + K_W'(1);
      end
    end else begin
      w_cnt_nxt = w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ST_HOLD;
      r_cnt        <= {CNT_W{1'b0}};
      r_k          <= {K_W{1'b0}};
      r_rstn_stage <= {N_STAGES{1'b0}};
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_timeout    <= {N_STAGES{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_k          <= w_k_nxt;
      r_rstn_stage <= w_rstn_stage_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign rstn_stage_o = r_rstn_stage;
  assign seq_busy_o   = r_busy;
  assign seq_done_o   = r_done;
  assign timeout_o    = r_timeout;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues hand-computed output
// change events (edge number + values); a negedge monitor pops on every change.
module tb_reset_sequencer;

  logic       clk_i;
  logic       rstn_i;
  logic       sw_rst_req_i;
  logic [3:0] stage_done_i;
  logic [3:0] rstn_stage_o;
  logic       seq_busy_o;
  logic       seq_done_o;
  logic [3:0] timeout_o;

  reset_sequencer #(
    .N_STAGES (4),
    .HOLD_CYC (8),
    .STAGE_DLY(4),
    .TIMEOUT  (64),
    .CNT_W    (8)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sw_rst_req_i(sw_rst_req_i),
    .stage_done_i(stage_done_i),
    .rstn_stage_o(rstn_stage_o),
    .seq_busy_o  (seq_busy_o),
    .seq_done_o  (seq_done_o),
    .timeout_o   (timeout_o)
  );

  typedef struct {
    int         e;
    logic [3:0] rs;
    logic       bz;
    logic       dn;
    logic [3:0] to;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  bit   mon_en = 1'b0;
  logic [10:0] prev;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) edge_cnt = edge_cnt + 1;

  // Monitor: any change of the observable outputs consumes one expected event.
  always @(negedge clk_i) begin
    logic [10:0] cur;
    exp_t x;
    cur = {rstn_stage_o, seq_busy_o, seq_done_o, timeout_o};
    if (mon_en && (cur !== prev)) begin
      tests = tests + 1;
      if (q.size() == 0) begin
        fails = fails + 1;
        $display("FAIL unexpected_change: edge=%0d rstn=%b busy=%b done=%b to=%b, no event queued",
                 edge_cnt, rstn_stage_o, seq_busy_o, seq_done_o, timeout_o);
      end else begin
        x = q.pop_front();
        if (x.e != edge_cnt || x.rs !== rstn_stage_o || x.bz !== seq_busy_o ||
            x.dn !== seq_done_o || x.to !== timeout_o) begin
          fails = fails + 1;
          $display("FAIL scoreboard: got edge=%0d rstn=%b busy=%b done=%b to=%b, expected edge=%0d rstn=%b busy=%b done=%b to=%b",
                   edge_cnt, rstn_stage_o, seq_busy_o, seq_done_o, timeout_o,
                   x.e, x.rs, x.bz, x.dn, x.to);
        end
      end
    end
    prev = cur;
  end

  task automatic push(input int e, input logic [3:0] rs, input logic bz,
                      input logic dn, input logic [3:0] to);
    exp_t x;
    x.e = e; x.rs = rs; x.bz = bz; x.dn = dn; x.to = to;
    q.push_back(x);
  endtask

  // Nominal sequence with all acks high; base is the edge before edge 1.
  task automatic push_seq(input int base);
    push(base + 12, 4'b0001, 1'b1, 1'b0, 4'b0000);
    push(base + 17, 4'b0011, 1'b1, 1'b0, 4'b0000);
    push(base + 22, 4'b0111, 1'b1, 1'b0, 4'b0000);
    push(base + 27, 4'b1111, 1'b1, 1'b0, 4'b0000);
    push(base + 28, 4'b1111, 1'b0, 1'b1, 4'b0000);
  endtask

  // Returns at the negedge following posedge number e.
  task automatic goto_edge(input int e);
    while (edge_cnt < e) @(negedge clk_i);
  endtask

  // Pulse sw_rst_req_i so that it is sampled at edge s.
  task automatic sw_pulse(input int s);
    goto_edge(s - 1);
    sw_rst_req_i = 1'b1;
    goto_edge(s);
    sw_rst_req_i = 1'b0;
  endtask

  task automatic check_now(input string name, input logic [10:0] exp);
    logic [10:0] got;
    got = {rstn_stage_o, seq_busy_o, seq_done_o, timeout_o};
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got rstn/busy/done/to=%b, expected %b", name, got, exp);
    end
  endtask

  initial begin
    int base;
    int s;
    rstn_i       = 1'b1;
    sw_rst_req_i = 1'b0;
    stage_done_i = 4'b1111;
    #1 rstn_i = 1'b0;
    #2 check_now("reset_values", {4'b0000, 1'b1, 1'b0, 4'b0000});
    prev   = {rstn_stage_o, seq_busy_o, seq_done_o, timeout_o};
    mon_en = 1'b1;

    // 1: nominal sequence after rstn_i release
    goto_edge(3);
    base = edge_cnt;
    push_seq(base);
    rstn_i = 1'b0 | 1'b1;
    goto_edge(base + 32);

    // 4: software re-reset from DONE replays the same timing
    s = base + 34;
    push(s, 4'b0000, 1'b1, 1'b0, 4'b0000);
    push_seq(s);
    sw_pulse(s);
    goto_edge(s + 32);

    // 2: stage 1 ack late by 10 cycles
    s = s + 34;
    push(s,      4'b0000, 1'b1, 1'b0, 4'b0000);
    push(s + 12, 4'b0001, 1'b1, 1'b0, 4'b0000);
    push(s + 17, 4'b0011, 1'b1, 1'b0, 4'b0000);
    push(s + 32, 4'b0111, 1'b1, 1'b0, 4'b0000);
    push(s + 37, 4'b1111, 1'b1, 1'b0, 4'b0000);
    push(s + 38, 4'b1111, 1'b0, 1'b1, 4'b0000);
    goto_edge(s - 1);
    stage_done_i = 4'b1101;
    sw_pulse(s);
    goto_edge(s + 27);
    stage_done_i = 4'b1111;
    goto_edge(s + 42);

    // 3: stage 2 ack stuck low -> timeout after 64 WAIT_ACK cycles
    s = s + 44;
    push(s,      4'b0000, 1'b1, 1'b0, 4'b0000);
    push(s + 12, 4'b0001, 1'b1, 1'b0, 4'b0000);
    push(s + 17, 4'b0011, 1'b1, 1'b0, 4'b0000);
    push(s + 22, 4'b0111, 1'b1, 1'b0, 4'b0000);
    push(s + 86, 4'b0111, 1'b1, 1'b0, 4'b0100);
    push(s + 90, 4'b1111, 1'b1, 1'b0, 4'b0100);
    push(s + 91, 4'b1111, 1'b0, 1'b1, 4'b0100);
    goto_edge(s - 1);
    stage_done_i = 4'b1011;
    sw_pulse(s);
    goto_edge(s + 94);
    check_now("timeout_done", {4'b1111, 1'b0, 1'b1, 4'b0100});

    // 5: software re-reset while waiting on stage 1's ack
    s = s + 96;
    push(s,      4'b0000, 1'b1, 1'b0, 4'b0000);
    push(s + 12, 4'b0001, 1'b1, 1'b0, 4'b0000);
    push(s + 17, 4'b0011, 1'b1, 1'b0, 4'b0000);
    goto_edge(s - 1);
    stage_done_i = 4'b1101;
    sw_pulse(s);
    base = s + 20;
    push(base,      4'b0000, 1'b1, 1'b0, 4'b0000);
    push(base + 12, 4'b0001, 1'b1, 1'b0, 4'b0000);
    push(base + 17, 4'b0011, 1'b1, 1'b0, 4'b0000);
    sw_pulse(base);
    stage_done_i = 4'b1111;

    // 6: async rstn_i mid-GAP of stage 2, then clean restart
    goto_edge(base + 20);
    @(posedge clk_i);
    #2;
    push(base + 21, 4'b0000, 1'b1, 1'b0, 4'b0000);
    rstn_i = 1'b0;
    #1 check_now("async_reset", {4'b0000, 1'b1, 1'b0, 4'b0000});
    goto_edge(base + 24);
    push_seq(base + 24);
    rstn_i = 1'b1;
    goto_edge(base + 24 + 32);

    tests = tests + 1;
    if (q.size() != 0) begin
      fails = fails + 1;
      $display("FAIL missing_events: %0d expected events never seen, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
